// File: rtl/lc2k_prog_loader.sv
// rtl/lc2k_prog_loader.sv - framed byte-stream boot loader writing LC2K instruction memory
module lc2k_prog_loader #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           words_loaded
);

    // 17 bits so a 16-bit address space (65536 words) is still representable
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    logic [15:0] len;
    logic [23:0] word;
    logic [1:0]  byte_idx;
    logic [7:0]  checksum;
    logic        accept;
    logic [15:0] len_next;

    assign accept   = in_valid && in_ready;
    assign len_next = {len[15:8], in_data};

    // Frame parser, word assembler and memory write strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            len          <= '0;
            word         <= '0;
            byte_idx     <= '0;
            checksum     <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        state <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= in_data;
                        state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= in_data;
                        checksum <= '0;
                        byte_idx <= '0;
                        if ({1'b0, len_next} > DEPTH) begin
                            state      <= S_ERROR;
                            in_ready   <= 1'b0;
                            load_error <= 1'b1;
                        end else if (len_next == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        checksum <= checksum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        word     <= {word[15:0], in_data};
                        if (byte_idx == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
                            mem_wdata    <= {word, in_data};
                            words_loaded <= words_loaded + 16'd1;
                            if (words_loaded + 16'd1 == len) begin
                                state <= S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == checksum) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                        end else begin
                            state      <= S_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    cpu_reset <= 1'b0;
                end
                S_ERROR: begin
                    cpu_reset <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc2k_prog_loader.sv
// tb/tb_lc2k_prog_loader.sv - directed self-checking bench for lc2k_prog_loader
module tb_lc2k_prog_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0]  frame[$];
    logic [7:0]  wr_addr[16];
    logic [31:0] wr_data[16];
    int          wr_cnt;
    int          bad_we;
    logic        prev_acc;

    lc2k_prog_loader #(.ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log writes and flag any strobe not preceded by an accepting edge
    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
            if (!prev_acc) bad_we = bad_we + 1;
        end
        prev_acc = in_valid && in_ready && !reset;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        wr_cnt = 0; bad_we = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic rdy;
        n = 0;
        in_data = b; in_valid = 1'b1;
        do begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 20);
        in_valid = 1'b0;
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout byte=%02h in_ready stuck low, required 1", b);
        end
    endtask

    task automatic send_frame(input int maxgap);
        for (int i = 0; i < frame.size(); i++) begin
            if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
            send_byte(frame[i]);
        end
    endtask

    task automatic check_nominal_result(input string tag);
        checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL %s wr_cnt got %0d want 2", tag, wr_cnt); end
        checks++; if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h00810007) begin errors++; $display("FAIL %s write0 got %0d/%08h want 0/00810007", tag, wr_addr[0], wr_data[0]); end
        checks++; if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h01C00000) begin errors++; $display("FAIL %s write1 got %0d/%08h want 1/01c00000", tag, wr_addr[1], wr_data[1]); end
        checks++; if (bad_we !== 0) begin errors++; $display("FAIL %s stray_we got %0d want 0", tag, bad_we); end
        @(negedge clk);
        checks++; if (load_done !== 1'b1 || load_error !== 1'b0) begin errors++; $display("FAIL %s done/err got %b/%b want 1/0", tag, load_done, load_error); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL %s cpu_reset_early got %b want 1", tag, cpu_reset); end
        checks++; if (in_ready !== 1'b0 || words_loaded !== 16'd2) begin errors++; $display("FAIL %s ready/words got %b/%0d want 0/2", tag, in_ready, words_loaded); end
        @(negedge clk);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL %s cpu_reset_fall got %b want 0", tag, cpu_reset); end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || mem_we !== 1'b0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_ctl got rdy=%b we=%b cpu=%b want 1/0/1", in_ready, mem_we, cpu_reset); end
        checks++; if (mem_addr !== 8'd0 || mem_wdata !== 32'd0 || words_loaded !== 16'd0) begin errors++; $display("FAIL reset_data got %0d/%08h/%0d want 0/0/0", mem_addr, mem_wdata, words_loaded); end
        checks++; if (load_done !== 1'b0 || load_error !== 1'b0) begin errors++; $display("FAIL reset_flags got %b/%b want 0/0", load_done, load_error); end
    endtask

    task automatic test_nominal();
        do_reset();
        frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h81, 8'h00, 8'h07, 8'h01, 8'hC0, 8'h00, 8'h00, 8'h47};
        send_frame(0);
        check_nominal_result("nominal");
    endtask

    task automatic test_bad_checksum();
        do_reset();
        frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h81, 8'h00, 8'h07, 8'h01, 8'hC0, 8'h00, 8'h00, 8'h48};
        send_frame(0);
        repeat (3) @(negedge clk);
        checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL badchk wr_cnt got %0d want 2", wr_cnt); end
        checks++; if (load_error !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL badchk err/done got %b/%b want 1/0", load_error, load_done); end
        checks++; if (cpu_reset !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL badchk cpu/rdy got %b/%b want 1/0", cpu_reset, in_ready); end
    endtask

    task automatic test_garbage_stall();
        do_reset();
        frame = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h02, 8'h00, 8'h81, 8'h00, 8'h07, 8'h01, 8'hC0, 8'h00, 8'h00, 8'h47};
        send_frame(5);
        check_nominal_result("stall");
    endtask

    task automatic test_oversize();
        do_reset();
        frame = '{8'hA5, 8'h01, 8'h01};
        send_frame(0);
        @(negedge clk);
        checks++; if (load_error !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL oversize err/rdy got %b/%b want 1/0", load_error, in_ready); end
        repeat (3) @(negedge clk);
        checks++; if (wr_cnt !== 0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL oversize wr/cpu got %0d/%b want 0/1", wr_cnt, cpu_reset); end
    endtask

    task automatic test_empty();
        do_reset();
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        repeat (2) @(negedge clk);
        checks++; if (load_done !== 1'b1 || load_error !== 1'b0) begin errors++; $display("FAIL empty done/err got %b/%b want 1/0", load_done, load_error); end
        checks++; if (words_loaded !== 16'd0 || wr_cnt !== 0 || cpu_reset !== 1'b0) begin errors++; $display("FAIL empty words/wr/cpu got %0d/%0d/%b want 0/0/0", words_loaded, wr_cnt, cpu_reset); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h81, 8'h00};
        send_frame(0);
        do_reset();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || words_loaded !== 16'd0 || cpu_reset !== 1'b1 || mem_wdata !== 32'd0) begin errors++; $display("FAIL midreset got rdy=%b words=%0d cpu=%b wd=%08h want 1/0/1/0", in_ready, words_loaded, cpu_reset, mem_wdata); end
        checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL midreset partial_write got %0d want 0", wr_cnt); end
        frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h81, 8'h00, 8'h07, 8'h01, 8'hC0, 8'h00, 8'h00, 8'h47};
        @(posedge clk); #1;
        send_frame(0);
        check_nominal_result("resend");
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        wr_cnt = 0; bad_we = 0; prev_acc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_garbage_stall();
        test_oversize();
        test_empty();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
